rf_sb: RTL and testbench

Parametrised register file with integrated write-pending scoreboard for the pipelined RV32I core. Provides NUM_RD asynchronous read ports, one synchronous write port, optional write-to-read bypass, and per-register busy bits. Busy bits are set when an instruction that writes a register issues, and cleared when its writeback lands. The block sits between decode, where it supplies operands and hazard flags, and writeback.

---
 rtl/rf_sb_pkg.sv | 15 +
 rtl/rf_sb_if.sv | 34 +++
 rtl/rf_sb_scoreboard.sv | 42 ++++
 rtl/rf_sb.sv | 67 ++++++
 tb/tb_rf_sb.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/rf_sb_pkg.sv
// Shared definitions for the register file / scoreboard slice: default sizes,
// address-width helper and the hardwired zero register index.
package rf_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int NUM_RD_DEF = 2;
  localparam int ZERO_REG   = 0;

  // A single-entry file still needs one address bit to form a legal port
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rf_sb_if.sv
// Decode/writeback-facing bundle of the register file: read ports, writeback,
// issue and flush. The master drives requests, the register file is the slave.
interface rf_sb_if
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);

  localparam int AW = addr_width(DEPTH);

  logic [NUM_RD*AW-1:0]   i_raddr;
  logic [NUM_RD*XLEN-1:0] o_rdata;
  logic [NUM_RD-1:0]      o_rbusy;
  logic                   o_hazard;
  logic                   i_wen;
  logic [AW-1:0]          i_waddr;
  logic [XLEN-1:0]        i_wdata;
  logic                   i_iss_valid;
  logic [AW-1:0]          i_iss_rd;
  logic                   i_flush;

  modport master (
    output i_raddr, i_wen, i_waddr, i_wdata, i_iss_valid, i_iss_rd, i_flush,
    input  o_rdata, o_rbusy, o_hazard
  );

  modport slave (
    input  i_raddr, i_wen, i_waddr, i_wdata, i_iss_valid, i_iss_rd, i_flush,
    output o_rdata, o_rbusy, o_hazard
  );

endinterface

// File: rtl/rf_sb_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, set on issue, cleared on
// writeback, wiped by flush. Register 0 never becomes busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_iss_valid,
  input  logic [AW-1:0]    i_iss_rd,
  input  logic             i_wen,
  input  logic [AW-1:0]    i_waddr,
  input  logic             i_flush,
  output logic [DEPTH-1:0] o_busy
);

  logic [DEPTH-1:0] busy_nxt;

  // Clear is applied before set so a same-cycle issue to the written register
  // keeps it busy: the newly issued producer is still outstanding.
  always_comb begin
    busy_nxt = o_busy;
    if (i_flush) begin
      busy_nxt = '0;
    end else begin
      if (i_wen && (i_waddr != AW'(ZERO_REG)))
        busy_nxt[i_waddr] = 1'b0;
      if (i_iss_valid && (i_iss_rd != AW'(ZERO_REG)))
        busy_nxt[i_iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_busy <= '0;
    else
      o_busy <= busy_nxt;
  end

endmodule

// File: rtl/rf_sb.sv
// Register file with NUM_RD combinational read ports, one write port, optional
// writeback bypass and per-register pending-write flags for decode hazards.
module rf_sb
  import rf_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int NUM_RD    = NUM_RD_DEF,
  parameter int BYPASS_EN = 0
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  rf_sb_if.slave bus
);

  localparam int AW = addr_width(DEPTH);

  logic [XLEN-1:0]  regs [DEPTH];
  logic [DEPTH-1:0] busy;

  wire [NUM_RD*XLEN-1:0] rdata_flat;
  wire [NUM_RD-1:0]      rbusy_flat;

  rf_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_scoreboard (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_iss_valid (bus.i_iss_valid),
    .i_iss_rd    (bus.i_iss_rd),
    .i_wen       (bus.i_wen),
    .i_waddr     (bus.i_waddr),
    .i_flush     (bus.i_flush),
    .o_busy      (busy)
  );

  // Entry 0 is reset and never written, so it stays zero as a backstop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (bus.i_wen && (bus.i_waddr != AW'(ZERO_REG))) begin
      regs[bus.i_waddr] <= bus.i_wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero;
    logic          wb_hit;

    assign addr    = bus.i_raddr[k*AW +: AW];
    assign is_zero = (addr == AW'(ZERO_REG));
    // A same-cycle writeback both forwards its data and retires the hazard
    assign wb_hit  = (BYPASS_EN != 0) && bus.i_wen && (bus.i_waddr == addr);

    assign rdata_flat[k*XLEN +: XLEN] = is_zero ? '0 :
                                        wb_hit  ? bus.i_wdata : regs[addr];
    assign rbusy_flat[k] = !is_zero && busy[addr] && !wb_hit;
  end

  assign bus.o_rdata  = rdata_flat;
  assign bus.o_rbusy  = rbusy_flat;
  assign bus.o_hazard = |rbusy_flat;

endmodule

// File: tb/tb_rf_sb.sv
// Directed bench for rf_sb: vector table on the default build, hand-written
// sequences for reset, bypass and a 16x64 four-port build.
module tb_rf_sb;

  logic i_clk;
  logic i_rst_n;

  int checks = 0;
  int errors = 0;

  rf_sb_if #(.XLEN(32), .DEPTH(32), .NUM_RD(2)) bus0 ();
  rf_sb_if #(.XLEN(32), .DEPTH(32), .NUM_RD(2)) bus1 ();
  rf_sb_if #(.XLEN(64), .DEPTH(16), .NUM_RD(4)) bus2 ();

  rf_sb #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .BYPASS_EN(0)) dut0 (
    .i_clk (i_clk), .i_rst_n (i_rst_n), .bus (bus0)
  );
  rf_sb #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .BYPASS_EN(1)) dut1 (
    .i_clk (i_clk), .i_rst_n (i_rst_n), .bus (bus1)
  );
  rf_sb #(.XLEN(64), .DEPTH(16), .NUM_RD(4), .BYPASS_EN(0)) dut2 (
    .i_clk (i_clk), .i_rst_n (i_rst_n), .bus (bus2)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        iss;
    logic [4:0]  iss_rd;
    logic        flush;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_busy;
    logic        e_haz;
  } vec_t;

  vec_t vecs [20];

  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    bus0.i_wen = 0; bus0.i_waddr = '0; bus0.i_wdata = '0;
    bus0.i_iss_valid = 0; bus0.i_iss_rd = '0; bus0.i_flush = 0;
    bus1.i_wen = 0; bus1.i_waddr = '0; bus1.i_wdata = '0;
    bus1.i_iss_valid = 0; bus1.i_iss_rd = '0; bus1.i_flush = 0;
    bus2.i_wen = 0; bus2.i_waddr = '0; bus2.i_wdata = '0;
    bus2.i_iss_valid = 0; bus2.i_iss_rd = '0; bus2.i_flush = 0;
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    @(negedge i_clk);
    bus0.i_wen       = v.wen;
    bus0.i_waddr     = v.waddr;
    bus0.i_wdata     = v.wdata;
    bus0.i_iss_valid = v.iss;
    bus0.i_iss_rd    = v.iss_rd;
    bus0.i_flush     = v.flush;
    bus0.i_raddr     = {v.ra1, v.ra0};
    #1;
    check_output($sformatf("vec%0d rdata0", idx), 64'(bus0.o_rdata[31:0]), 64'(v.e_rd0));
    check_output($sformatf("vec%0d rdata1", idx), 64'(bus0.o_rdata[63:32]), 64'(v.e_rd1));
    check_output($sformatf("vec%0d rbusy", idx), 64'(bus0.o_rbusy), 64'(v.e_busy));
    check_output($sformatf("vec%0d hazard", idx), 64'(bus0.o_hazard), 64'(v.e_haz));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //          wen waddr  wdata         iss rd    fl  ra0    ra1    e_rd0         e_rd1         busy   haz
    vecs[0]  = '{1, 5'd7,  32'h12345678, 0,  5'd0, 0,  5'd7,  5'd0,  32'h0,        32'h0,        2'b00, 0};
    vecs[1]  = '{0, 5'd0,  32'h0,        0,  5'd0, 0,  5'd7,  5'd0,  32'h12345678, 32'h0,        2'b00, 0};
    vecs[2]  = '{1, 5'd0,  32'hFFFFFFFF, 0,  5'd0, 0,  5'd0,  5'd7,  32'h0,        32'h12345678, 2'b00, 0};
    vecs[3]  = '{0, 5'd0,  32'h0,        0,  5'd0, 0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 0};
    vecs[4]  = '{0, 5'd0,  32'h0,        1,  5'd9, 0,  5'd9,  5'd7,  32'h0,        32'h12345678, 2'b00, 0};
    vecs[5]  = '{1, 5'd9,  32'h11,       1,  5'd9, 0,  5'd9,  5'd9,  32'h0,        32'h0,        2'b11, 1};
    vecs[6]  = '{0, 5'd0,  32'h0,        0,  5'd0, 0,  5'd9,  5'd0,  32'h11,       32'h0,        2'b01, 1};
    vecs[7]  = '{0, 5'd0,  32'h0,        1,  5'd0, 0,  5'd0,  5'd9,  32'h0,        32'h11,       2'b10, 1};
    vecs[8]  = '{1, 5'd9,  32'h22,       0,  5'd0, 0,  5'd0,  5'd9,  32'h0,        32'h11,       2'b10, 1};
    vecs[9]  = '{0, 5'd0,  32'h0,        0,  5'd0, 0,  5'd9,  5'd0,  32'h22,       32'h0,        2'b00, 0};
    vecs[10] = '{0, 5'd0,  32'h0,        1,  5'd4, 0,  5'd4,  5'd4,  32'h0,        32'h0,        2'b00, 0};
    vecs[11] = '{0, 5'd0,  32'h0,        1,  5'd4, 0,  5'd4,  5'd0,  32'h0,        32'h0,        2'b01, 1};
    vecs[12] = '{1, 5'd4,  32'h44,       0,  5'd0, 0,  5'd4,  5'd0,  32'h0,        32'h0,        2'b01, 1};
    vecs[13] = '{0, 5'd0,  32'h0,        0,  5'd0, 0,  5'd4,  5'd0,  32'h44,       32'h0,        2'b00, 0};
    vecs[14] = '{0, 5'd0,  32'h0,        1,  5'd1, 0,  5'd1,  5'd2,  32'h0,        32'h0,        2'b00, 0};
    vecs[15] = '{0, 5'd0,  32'h0,        1,  5'd2, 0,  5'd1,  5'd2,  32'h0,        32'h0,        2'b01, 1};
    vecs[16] = '{0, 5'd0,  32'h0,        1,  5'd31,0,  5'd1,  5'd2,  32'h0,        32'h0,        2'b11, 1};
    vecs[17] = '{1, 5'd31, 32'h31313131, 1,  5'd6, 1,  5'd31, 5'd6,  32'h0,        32'h0,        2'b01, 1};
    vecs[18] = '{0, 5'd0,  32'h0,        0,  5'd0, 0,  5'd31, 5'd6,  32'h31313131, 32'h0,        2'b00, 0};
    vecs[19] = '{0, 5'd0,  32'h0,        0,  5'd0, 0,  5'd1,  5'd2,  32'h0,        32'h0,        2'b00, 0};

    idle_all();
    bus0.i_raddr = {5'd7, 5'd5};
    bus1.i_raddr = '0;
    bus2.i_raddr = '0;
    i_rst_n = 1'b0;
    #1;
    check_output("reset rdata", 64'(bus0.o_rdata), 64'h0);
    check_output("reset hazard", 64'(bus0.o_hazard), 64'h0);
    #11 i_rst_n = 1'b1;

    // Reset in the middle of operation wipes data and pending writes
    @(negedge i_clk);
    bus0.i_wen = 1; bus0.i_waddr = 5'd5; bus0.i_wdata = 32'hDEADBEEF;
    bus0.i_iss_valid = 1; bus0.i_iss_rd = 5'd8;
    bus0.i_raddr = {5'd8, 5'd5};
    @(negedge i_clk);
    idle_all();
    #1;
    check_output("pre-reset x5", 64'(bus0.o_rdata[31:0]), 64'hDEADBEEF);
    check_output("pre-reset hazard", 64'(bus0.o_hazard), 64'h1);
    #1 i_rst_n = 1'b0;
    #1;
    check_output("mid-reset x5", 64'(bus0.o_rdata[31:0]), 64'h0);
    check_output("mid-reset rbusy", 64'(bus0.o_rbusy), 64'h0);
    check_output("mid-reset hazard", 64'(bus0.o_hazard), 64'h0);
    #1 i_rst_n = 1'b1;

    for (int i = 0; i < 20; i++)
      apply_stimulus(vecs[i], i);
    @(negedge i_clk);
    idle_all();

    // Bypass build: writeback forwards data and retires the hazard at once
    @(negedge i_clk);
    bus1.i_iss_valid = 1; bus1.i_iss_rd = 5'd3;
    bus1.i_raddr = {5'd3, 5'd0};
    #1;
    check_output("byp issue-cycle rbusy", 64'(bus1.o_rbusy), 64'h0);
    @(negedge i_clk);
    bus1.i_iss_valid = 0; bus1.i_iss_rd = '0;
    #1;
    check_output("byp x3 busy", 64'(bus1.o_rbusy), 64'h2);
    check_output("byp x3 hazard", 64'(bus1.o_hazard), 64'h1);
    @(negedge i_clk);
    bus1.i_wen = 1; bus1.i_waddr = 5'd3; bus1.i_wdata = 32'hA5A5A5A5;
    #1;
    check_output("byp wb rdata1", 64'(bus1.o_rdata[63:32]), 64'hA5A5A5A5);
    check_output("byp wb rbusy", 64'(bus1.o_rbusy), 64'h0);
    check_output("byp wb hazard", 64'(bus1.o_hazard), 64'h0);
    @(negedge i_clk);
    bus1.i_waddr = 5'd0; bus1.i_wdata = 32'h000000FF;
    #1;
    check_output("byp x0 write rdata0", 64'(bus1.o_rdata[31:0]), 64'h0);
    check_output("byp x3 stored", 64'(bus1.o_rdata[63:32]), 64'hA5A5A5A5);
    check_output("byp post rbusy", 64'(bus1.o_rbusy), 64'h0);
    @(negedge i_clk);
    bus1.i_wen = 0;

    // Wide four-port build with the top address in play
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      bus2.i_wen = 1;
      case (i)
        0: begin bus2.i_waddr = 4'd15; bus2.i_wdata = 64'hF0F0_0000_0000_000F; end
        1: begin bus2.i_waddr = 4'd1;  bus2.i_wdata = 64'h1111_2222_3333_4444; end
        2: begin bus2.i_waddr = 4'd2;  bus2.i_wdata = 64'h8000_0000_0000_0001; end
        default: begin bus2.i_waddr = 4'd3; bus2.i_wdata = 64'hDEAD_BEEF_CAFE_F00D; end
      endcase
    end
    @(negedge i_clk);
    bus2.i_wen = 0;
    bus2.i_raddr = {4'd3, 4'd2, 4'd1, 4'd15};
    #1;
    check_output("wide p0 x15", bus2.o_rdata[63:0],    64'hF0F0_0000_0000_000F);
    check_output("wide p1 x1",  bus2.o_rdata[127:64],  64'h1111_2222_3333_4444);
    check_output("wide p2 x2",  bus2.o_rdata[191:128], 64'h8000_0000_0000_0001);
    check_output("wide p3 x3",  bus2.o_rdata[255:192], 64'hDEAD_BEEF_CAFE_F00D);
    @(negedge i_clk);
    bus2.i_raddr = {4'd1, 4'd3, 4'd15, 4'd0};
    bus2.i_iss_valid = 1; bus2.i_iss_rd = 4'd15;
    #1;
    check_output("wide p0 x0",  bus2.o_rdata[63:0],    64'h0);
    check_output("wide p1 x15", bus2.o_rdata[127:64],  64'hF0F0_0000_0000_000F);
    check_output("wide p2 x3",  bus2.o_rdata[191:128], 64'hDEAD_BEEF_CAFE_F00D);
    check_output("wide p3 x1",  bus2.o_rdata[255:192], 64'h1111_2222_3333_4444);
    check_output("wide issue-cycle rbusy", 64'(bus2.o_rbusy), 64'h0);
    @(negedge i_clk);
    bus2.i_iss_valid = 0; bus2.i_iss_rd = '0;
    #1;
    check_output("wide x15 rbusy", 64'(bus2.o_rbusy), 64'h2);
    check_output("wide x15 hazard", 64'(bus2.o_hazard), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
